// File: rtl/cordic_fp_pkg.sv
// cordic_fp_pkg: shared defaults and types for the CORDIC floating-point normaliser
// Contents: default widths, leading-zero count width, saturated exponent and stage-1 payload layout.
package cordic_fp_pkg;
    localparam int IN_W_DEF  = 48;
    localparam int MAN_W_DEF = 24;
    localparam int EXP_W_DEF = 8;
    localparam int LZ_W      = $clog2(IN_W_DEF);
    localparam int EXP_MAX   = (1 << EXP_W_DEF) - 1;
    typedef struct packed {
        logic [IN_W_DEF-1:0]  mant;
        logic [EXP_W_DEF-1:0] exp;
        logic [LZ_W-1:0]      lz;
        logic                 zero;
    } s1_payload_t;
endpackage

// File: rtl/cordic_fp_normalize_pipe_lzc.sv
// cordic_fp_lzc: combinational leading-zero counter built as a pairwise OR/mux tree
// Ports: d_i (W-bit word), lz_o (zeros above the leading one), zero_o (d_i is all zeros).
module cordic_fp_lzc #(
    parameter int W = 48
) (
    input  logic [W-1:0]         d_i,
    output logic [$clog2(W)-1:0] lz_o,
    output logic                 zero_o
);
    localparam int LW = $clog2(W);
    localparam int P  = 1 << LW;
    genvar k, j;
    for (k = 0; k <= LW; k++) begin : g_lvl
        logic [(P>>k)-1:0]    v;
        logic [(P>>k)*LW-1:0] c;
        if (k == 0) begin : g_leaf
            // pad on the right so the word is MSB-aligned in a power-of-two tree
            assign v = P'(d_i) << (P - W);
            assign c = '0;
        end else begin : g_node
            for (j = 0; j < (P >> k); j++) begin : g_pair
                assign v[j] = g_lvl[k-1].v[2*j+1] | g_lvl[k-1].v[2*j];
                // high half empty: count all its 2^(k-1) zeros plus the low half's count
                assign c[j*LW +: LW] = g_lvl[k-1].v[2*j+1] ? g_lvl[k-1].c[(2*j+1)*LW +: LW]
                                                           : (g_lvl[k-1].c[2*j*LW +: LW] | LW'(1 << (k-1)));
            end
        end
    end
    assign lz_o   = g_lvl[LW].c;
    assign zero_o = !g_lvl[LW].v[0];
endmodule

// File: rtl/cordic_fp_normalize_pipe.sv
// cordic_fp_normalize_pipe: two-stage leading-one normaliser with valid/ready backpressure
// Ports: clk, reset_n (async active-low); in_valid/in_ready/in_mant/in_exp input beat;
// out_valid/out_ready/out_mant/out_exp/out_shift/out_zero/out_uflow/out_oflow output beat.
// Build option: CORDIC_FP_NORM_ROUND_EN selects round-to-nearest-even instead of truncation.
module cordic_fp_normalize_pipe
    import cordic_fp_pkg::*;
#(
    parameter int IN_W  = cordic_fp_pkg::IN_W_DEF,
    parameter int MAN_W = cordic_fp_pkg::MAN_W_DEF,
    parameter int EXP_W = cordic_fp_pkg::EXP_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_W-1:0]         in_mant,
    input  logic [EXP_W-1:0]        in_exp,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [MAN_W-1:0]        out_mant,
    output logic [EXP_W-1:0]        out_exp,
    output logic [$clog2(IN_W)-1:0] out_shift,
    output logic                    out_zero,
    output logic                    out_uflow,
    output logic                    out_oflow
);
    localparam int LW   = $clog2(IN_W);
    localparam int EW   = EXP_W + 2;
    localparam int EMAX = (1 << EXP_W) - 1;
    typedef struct packed {
        logic [IN_W-1:0]  mant;
        logic [EXP_W-1:0] exp;
        logic [LW-1:0]    lz;
        logic             zero;
    } s1_t;
    s1_t              s1_q;
    logic             s1_valid_q, out_valid_q, s1_ready;
    logic [LW-1:0]    lz;
    logic             lz_zero;
    logic [EW-1:0]    e, e_r;
    logic [MAN_W-1:0] mant_r;
    logic             uflow, oflow;
    logic [MAN_W-1:0] out_mant_q, out_mant_d;
    logic [EXP_W-1:0] out_exp_q, out_exp_d;
    logic [LW-1:0]    out_shift_q, out_shift_d;
    logic             out_zero_q, out_zero_d, out_uflow_q, out_oflow_q;
    cordic_fp_lzc #(.W(IN_W)) u_lzc (.d_i(in_mant), .lz_o(lz), .zero_o(lz_zero));
    assign s1_ready = !out_valid_q | out_ready;
    assign in_ready = !s1_valid_q | s1_ready;
    // signed exponent with headroom: +1 because the binary point sits below two integer bits
    assign e = EW'(s1_q.exp) + EW'(1) - EW'(s1_q.lz);
`ifdef CORDIC_FP_NORM_ROUND_EN
    logic [IN_W+1:0]  ext;
    logic [MAN_W:0]   rnd;
    logic             up;
    // two zero pad bits keep guard/sticky slices legal even when MAN_W == IN_W
    assign ext    = {s1_q.mant << s1_q.lz, 2'b00};
    assign up     = ext[IN_W+1-MAN_W] & ((|ext[IN_W-MAN_W:0]) | ext[IN_W+2-MAN_W]);
    assign rnd    = {1'b0, ext[IN_W+1 -: MAN_W]} + (MAN_W+1)'(up);
    assign mant_r = rnd[MAN_W] ? {1'b1, {(MAN_W-1){1'b0}}} : rnd[MAN_W-1:0];
    assign e_r    = e + EW'(rnd[MAN_W]);
`else
    assign mant_r = MAN_W'((s1_q.mant << s1_q.lz) >> (IN_W - MAN_W));
    assign e_r    = e;
`endif
    assign uflow       = !s1_q.zero & (e_r[EW-1] | (e_r == '0));
    assign oflow       = !s1_q.zero & !e_r[EW-1] & (e_r >= EW'(EMAX));
    assign out_mant_d  = (s1_q.zero | uflow | oflow) ? '0 : mant_r;
    assign out_exp_d   = oflow ? '1 : (s1_q.zero | uflow) ? '0 : e_r[EXP_W-1:0];
    assign out_shift_d = s1_q.zero ? '0 : s1_q.lz;
    assign out_zero_d  = s1_q.zero | uflow;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            out_mant_q  <= '0;
            out_exp_q   <= '0;
            out_shift_q <= '0;
            out_zero_q  <= 1'b0;
            out_uflow_q <= 1'b0;
            out_oflow_q <= 1'b0;
        end else begin
            if (in_ready) s1_valid_q <= in_valid;
            if (in_valid && in_ready) s1_q <= {in_mant, in_exp, lz, lz_zero};
            if (s1_ready) out_valid_q <= s1_valid_q;
            if (s1_valid_q && s1_ready) begin
                out_mant_q  <= out_mant_d;
                out_exp_q   <= out_exp_d;
                out_shift_q <= out_shift_d;
                out_zero_q  <= out_zero_d;
                out_uflow_q <= uflow;
                out_oflow_q <= oflow;
            end
        end
    end
    assign out_valid = out_valid_q;
    assign out_mant  = out_mant_q;
    assign out_exp   = out_exp_q;
    assign out_shift = out_shift_q;
    assign out_zero  = out_zero_q;
    assign out_uflow = out_uflow_q;
    assign out_oflow = out_oflow_q;
endmodule

// File: doc/cordic_fp_normalize_pipe.md
# cordic_fp_normalize_pipe

Parametrised, pipelined floating-point normaliser for the CORDIC datapath. It takes a raw fixed-point product mantissa (default 48 bits, from the 24×24 K-multiply) and its biased exponent. It locates the leading one, shifts the mantissa left to MAN_W bits and adjusts the exponent, flagging zero, underflow and overflow. A valid/ready handshake with full backpressure lets it sit between the multiplier and the rotation stages.

## Interface
Parameters:
- IN_W, 48, width of raw mantissa; binary point lies between bits IN_W-2 and IN_W-3 (two integer bits).
- MAN_W, 24, width of normalised output mantissa (hidden bit included, MSB = 1 when nonzero); MAN_W ≤ IN_W.
- EXP_W, 8, biased exponent width.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts beat this cycle.
- in_mant  in  IN_W  raw mantissa.
- in_exp  in  EXP_W  biased exponent of in_mant.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts beat.
- out_mant  out  MAN_W  normalised mantissa.
- out_exp  out  EXP_W  adjusted biased exponent.
- out_shift  out  $clog2(IN_W)  leading-zero count applied.
- out_zero  out  1  result is zero (input zero or underflow flush).
- out_uflow  out  1  exponent underflow, flushed to zero.
- out_oflow  out  1  exponent overflow, saturated.

## Operation
- Stage 1 (LZC): lz = IN_W-1 − index of the MSB set in in_mant; zero = (in_mant == 0). Register in_mant, in_exp, lz and zero.
- Stage 2 (shift/adjust): m = in_mant << lz; out_mant = m[IN_W-1 -: MAN_W].
- Stage 2 exponent: e = in_exp + 1 − lz, computed signed in EXP_W+2 bits.
- Zero input: out_zero=1; out_mant, out_exp, out_shift all 0; uflow/oflow 0.
- Underflow, e ≤ 0 with nonzero input: out_zero=1, out_uflow=1, out_mant=0, out_exp=0; out_shift still reports lz.
- Overflow, e ≥ 2^EXP_W−1: out_oflow=1, out_exp = all ones, out_mant=0.
- Otherwise: out_exp = e[EXP_W-1:0]; all flags 0.
- Flags are mutually exclusive except zero with uflow.

## Timing
- Latency 2 cycles from an accepted input to out_valid, with out_ready held high. Throughput is 1 beat per cycle.
- in_ready = !s1_valid | s1_ready.
- s1_ready = !out_valid | out_ready.
- Beat transfer occurs when valid & ready are both high on a rising clk edge.
- While out_valid=1 & out_ready=0, all out_* data are held stable.
- With the pipeline full and out_ready=0, in_ready=0; at most 2 beats are held. No beats are dropped or reordered.
- Simultaneous output drain and input accept in the same cycle is allowed; the pipeline advances in lockstep.
- Reset: all valids 0 and all data registers 0, so out_* = 0 and in_ready = 1 once reset_n is high.
- Reset mid-operation discards in-flight beats immediately (asynchronous).

## Configuration
- CORDIC_FP_NORM_ROUND_EN defined: round to nearest-even.
  - guard = m[IN_W-1-MAN_W]; sticky = OR of the lower bits; round up if guard & (sticky | lsb).
  - Mantissa carry-out sets out_mant = 1000…0 and e += 1. Overflow is checked after rounding.
  - Latency remains 2; rounding is done within stage 2.
- Not defined: truncation; the guard and sticky bits are ignored.

## Structure
- Package cordic_fp_pkg holds:
  - IN_W/MAN_W/EXP_W defaults;
  - LZ_W = $clog2(IN_W);
  - the EXP_MAX constant;
  - a struct typedef for the stage-1 payload (mant, exp, lz, zero).
- Sub-module cordic_fp_lzc: a combinational, parametrised pairwise OR/mux tree leading-zero counter (IN_W → lz, zero), instantiated in stage 1.

## Test plan
Defaults IN_W=48, MAN_W=24, EXP_W=8.
- in_mant=48'h800000000000, in_exp=127 → out_mant=24'h800000, out_exp=128, out_shift=0, all flags 0, appears 2 cycles after accept.
- in_mant=48'h400000000000, in_exp=127 → out_mant=24'h800000, out_exp=127, out_shift=1.
- in_mant=0, in_exp=90 → out_zero=1, out_mant=0, out_exp=0, out_shift=0. Also in_mant=48'h1, in_exp=10 → out_uflow=1, out_zero=1, out_shift=47.
- in_mant=48'h800000000000, in_exp=254 → out_oflow=1, out_exp=8'hFF, out_mant=0.
- Backpressure: 4 back-to-back beats, out_ready=0 for 3 cycles → in_ready drops after 2 beats are held. Output held stable; all 4 beats emerge in order after release.
- in_mant=48'hFFFFFF800000, in_exp=100:
  - with CORDIC_FP_NORM_ROUND_EN → out_mant=24'h800000, out_exp=102;
  - without it → out_mant=24'hFFFFFF, out_exp=101.
